// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared defaults, FSM encodings and lane helper for the systolic sequencer.
package systolic_pkg;
   localparam int N_DEF  = 4;
   localparam int DW_DEF = 16;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_FEED  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Low bit of a lane within a flattened N*DW bus.
   function automatic int lane_lo(input int lane, input int dw);
      return lane * dw;
   endfunction
endpackage

// File: rtl/systolic_seq_ctrl_operand_bank.sv
// NxN operand register bank: one write port, N combinational read ports.
// COL_PORTS=0: port p reads mem[p][idx] (row lanes, matrix A).
// COL_PORTS=1: port p reads mem[idx][p] (column lanes, matrix B).
module operand_bank
   import systolic_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int DW        = DW_DEF,
   parameter int COL_PORTS = 0,
   parameter int AW        = $clog2(N)
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic [2*AW-1:0]           wr_addr,
   input  logic [DW-1:0]             wr_data,
   input  logic [N-1:0][AW-1:0]      rd_idx,
   output logic [N-1:0][DW-1:0]      rd_data
);
   logic [N-1:0][N-1:0][DW-1:0] mem;

   // Element storage; deliberately unreset so contents survive rst and runs.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr[2*AW-1:AW]][wr_addr[AW-1:0]] <= wr_data;
   end

   for (genvar p = 0; p < N; p++) begin : g_rd
      if (COL_PORTS != 0) begin : g_col
         assign rd_data[p] = mem[rd_idx[p]][p];
      end else begin : g_row
         assign rd_data[p] = mem[p][rd_idx[p]];
      end
   end
endmodule

// File: rtl/systolic_seq_ctrl.sv
// Systolic array sequencer: buffers A/B, clears the array, streams skewed
// operands west/north, waits out the drain and pulses done.
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic                      wr_sel,
   input  logic [2*$clog2(N)-1:0]    wr_addr,
   input  logic [DW-1:0]             wr_data,
   output logic                      wr_err,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      arr_rst,
   output logic [N*DW-1:0]           west,
   output logic [N*DW-1:0]           north,
   output logic [$clog2(3*N):0]      step
);
   localparam int AW = $clog2(N);
   localparam int SW = $clog2(3*N) + 1;

   logic [2:0]              state, state_nxt;
   logic [SW-1:0]           t_nxt;
   logic [N-1:0][AW-1:0]    k_idx;
   logic [N-1:0][DW-1:0]    a_rd, b_rd, west_nxt, north_nxt, west_q, north_q;
   logic                    wr_ok;

   assign busy    = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
   assign done    = (state == S_DONE);
   assign arr_rst = rst || (state == S_CLEAR);
   assign wr_ok   = wr_en && ((state == S_IDLE) || (state == S_DONE));

   operand_bank #(.N(N), .DW(DW), .COL_PORTS(0)) u_bank_a (
      .clk(clk), .wr_en(wr_ok && !wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_idx(k_idx), .rd_data(a_rd)
   );

   operand_bank #(.N(N), .DW(DW), .COL_PORTS(1)) u_bank_b (
      .clk(clk), .wr_en(wr_ok && wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_idx(k_idx), .rd_data(b_rd)
   );

   // Next state and next step index; step is 0 outside FEED/DRAIN.
   always_comb begin
      state_nxt = state;
      t_nxt     = '0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CLEAR;
         S_CLEAR: state_nxt = S_FEED;
         S_FEED: begin
            t_nxt = step + 1'b1;
            if (step == SW'(2*N-2)) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (step == SW'(3*N-3)) state_nxt = S_DONE;
            else                    t_nxt = step + 1'b1;
         end
         S_DONE:  state_nxt = start ? S_CLEAR : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Skew/gating for the upcoming cycle. Lane i (row for A, column for B)
   // carries element k = t-i. When t < i the subtraction wraps far above N
   // (the step width leaves headroom), so one compare covers both bounds.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [SW-1:0] k;
      logic          k_ok;
      assign k        = t_nxt - SW'(i);
      assign k_ok     = (state_nxt == S_FEED) && (k < SW'(N));
      assign k_idx[i] = k[AW-1:0];
      assign west_nxt[i]  = k_ok ? a_rd[i] : '0;
      assign north_nxt[i] = k_ok ? b_rd[i] : '0;
      assign west[lane_lo(i, DW) +: DW]  = west_q[i];
      assign north[lane_lo(i, DW) +: DW] = north_q[i];
   end

   // Control state and all registered array-facing outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         step    <= '0;
         west_q  <= '0;
         north_q <= '0;
         wr_err  <= 1'b0;
      end else begin
         state   <= state_nxt;
         step    <= t_nxt;
         west_q  <= west_nxt;
         north_q <= north_nxt;
         wr_err  <= wr_en && !wr_ok;
      end
   end
endmodule
